mmio_responder: RTL

- Bus-side responder for the core's single-port memory interface (address, data, we). It decodes the I/O window where address[11]=1.
- Captures core writes into a FIFO and drains them to a host/console port with a valid/ready handshake.
- Serves status reads and latches a halt event when the core writes the halt address 0xFFC.
- Sits beside the memory; an external mux uses `hit` to select this block's read data.

---
 rtl/mmio_responder_if.sv | 25 ++
 rtl/mmio_responder.sv | 103 ++++++++++
 2 files changed

// File: rtl/mmio_responder_if.sv
// Core-side bus and host-side drain port of the MMIO responder.
// The responder takes the slave view; the core/host pair takes the master view.
interface mmio_responder_if;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        we;
  logic [31:0] data_out;
  logic        hit;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_addr;
  logic [31:0] out_data;
  logic        halted;
  logic [31:0] halt_code;

  modport slave (
    input  address, data_in, we, out_ready,
    output data_out, hit, out_valid, out_addr, out_data, halted, halt_code
  );

  modport master (
    output address, data_in, we, out_ready,
    input  data_out, hit, out_valid, out_addr, out_data, halted, halt_code
  );
endinterface

// File: rtl/mmio_responder.sv
// MMIO responder for the I/O window (address[11]=1): queues core writes for the
// host, serves status/halt-code reads with one cycle latency and latches halt.
module mmio_responder #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] HALT_ADDR = 32'h0000_0FFC,
  parameter logic [31:0] STAT_ADDR = 32'h0000_0FF0,
  parameter logic [31:0] CODE_ADDR = 32'h0000_0FF4
) (
  input  logic         clk,
  input  logic         reset,
  mmio_responder_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [43:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    overflow_cnt;
  logic [7:0]    count8;
  logic [43:0]   head;
  logic          in_win, is_halt, is_stat, push_req;
  logic          pop, push, drop, full, empty;
  logic [31:0]   data_out_r, halt_code_r;
  logic          halted_r;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign in_win   = bus.we && bus.address[11];
  assign is_halt  = in_win && (bus.address == HALT_ADDR);
  assign is_stat  = in_win && (bus.address == STAT_ADDR);
  assign push_req = in_win && !is_halt && !is_stat;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign count8 = 8'(count);
  assign pop    = !empty && bus.out_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push   = push_req && (!full || pop);
  assign drop   = push_req && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (is_stat)   overflow_cnt <= '0;
      else if (drop) overflow_cnt <= sat_inc8(overflow_cnt);
    end
  end

  // Storage is pure data; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.address[11:0], bus.data_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_r    <= 1'b0;
      halt_code_r <= '0;
    end else if (is_halt) begin
      halted_r    <= 1'b1;
      halt_code_r <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_r <= '0;
    end else if (bus.we) begin
      data_out_r <= '0;
    end else if (bus.address == STAT_ADDR) begin
      data_out_r <= {8'h00, overflow_cnt, 5'b0, halted_r, full, empty, count8};
    end else if (bus.address == CODE_ADDR) begin
      data_out_r <= halt_code_r;
    end else begin
      data_out_r <= '0;
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.hit       = bus.address[11];
  assign bus.out_valid = !empty;
  assign bus.out_addr  = empty ? 12'h000 : head[43:32];
  assign bus.out_data  = empty ? 32'h0   : head[31:0];
  assign bus.halted    = halted_r;
  assign bus.halt_code = halt_code_r;
  assign bus.data_out  = data_out_r;

endmodule
